ksa8_rr_arbiter: RTL and testbench

- Shares one instance of the team's 8-bit Kogge-Stone adder (KSA_8bit, 8b+8b -> 9b, combinational) between NREQ requesters.
- Round-robin arbiter with per-requester valid/ready inputs, a registered result stage with a valid/ready output, and optional multi-beat locking.
- Sits between the vedic multiplier partial-product generators and their shared accumulate adder.

---
 rtl/ksa8_rr_arbiter.sv | 113 +++++++++++
 tb/tb_ksa8_rr_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ksa8_rr_arbiter.sv
// Round-robin arbiter sharing one 8-bit Kogge-Stone adder between NREQ requesters,
// with optional multi-beat locking and a registered valid/ready result stage.

module KSA_8bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [8:0] sum
);
  logic [7:0] g0, p0, g1, p1, g2, p2, g3;

  always_comb begin
    g0 = a & b;
    p0 = a ^ b;
    // Prefix span doubles each level: 1, 2, 4 bits.
    g1 = g0 | (p0 & {g0[6:0], 1'b0});
    p1 = p0 & {p0[6:0], 1'b1};
    g2 = g1 | (p1 & {g1[5:0], 2'b00});
    p2 = p1 & {p1[5:0], 2'b11};
    g3 = g2 | (p2 & {g2[3:0], 4'b0000});
    sum = {g3[7], p0 ^ {g3[6:0], 1'b0}};
  end
endmodule

module ksa8_rr_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [NREQ-1:0]     req_lock,
  input  logic [NREQ*8-1:0]   req_a,
  input  logic [NREQ*8-1:0]   req_b,
  output logic [NREQ-1:0]     req_ready,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [8:0]          res_sum,
  output logic [IDW-1:0]      res_id,
  output logic                res_last
);
  typedef enum logic {StArb, StLocked} state_e;

  localparam logic [IDW:0]   NreqW   = (IDW+1)'(NREQ);
  localparam logic [IDW-1:0] LastIdx = IDW'(NREQ - 1);

  state_e         state_q;
  logic [IDW-1:0] ptr_q, owner_q;
  logic [IDW-1:0] gnt_idx, ptr_next;
  logic           found, cap, accept;
  logic [7:0]     sel_a, sel_b;
  logic [8:0]     ksa_sum;

  always_comb begin : grant
    logic [IDW:0] cand;
    cap     = ~res_valid | res_ready;
    found   = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    if (state_q == StLocked) begin
      found   = req_valid[owner_q];
      gnt_idx = owner_q;
    end else begin
      // First valid requester at or after ptr, wrapping at NREQ-1.
      for (int unsigned k = 0; k < NREQ; k++) begin
        cand = {1'b0, ptr_q} + (IDW+1)'(k);
        if (cand >= NreqW) cand = cand - NreqW;
        if (!found && req_valid[cand[IDW-1:0]]) begin
          found   = 1'b1;
          gnt_idx = cand[IDW-1:0];
        end
      end
    end
    accept             = cap & found;
    req_ready          = '0;
    req_ready[gnt_idx] = accept;
  end

  always_comb begin
    sel_a    = req_a[8*gnt_idx +: 8];
    sel_b    = req_b[8*gnt_idx +: 8];
    ptr_next = (gnt_idx == LastIdx) ? '0 : gnt_idx + 1'b1;
  end

  KSA_8bit u_ksa (
    .a   (sel_a),
    .b   (sel_b),
    .sum (ksa_sum)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StArb;
      ptr_q     <= '0;
      owner_q   <= '0;
      res_valid <= 1'b0;
      res_sum   <= '0;
      res_id    <= '0;
      res_last  <= 1'b0;
    end else begin
      if (accept) begin
        res_valid <= 1'b1;
        res_sum   <= ksa_sum;
        res_id    <= gnt_idx;
        res_last  <= ~req_lock[gnt_idx];
        ptr_q     <= ptr_next;
        owner_q   <= gnt_idx;
        state_q   <= req_lock[gnt_idx] ? StLocked : StArb;
      end else if (res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_ksa8_rr_arbiter.sv
// Randomized and directed bench for ksa8_rr_arbiter against a rule-level reference model.

module tb_ksa8_rr_arbiter;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_lock = '0;
  logic [NREQ*8-1:0] req_a = '0;
  logic [NREQ*8-1:0] req_b = '0;
  logic [NREQ-1:0]   req_ready;
  logic              res_valid;
  logic              res_ready = 1'b1;
  logic [8:0]        res_sum;
  logic [IDW-1:0]    res_id;
  logic              res_last;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int         m_ptr, m_owner, m_id;
  bit         m_locked, m_rv, m_last;
  logic [8:0] m_sum;

  ksa8_rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_lock  (req_lock),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_sum   (res_sum),
    .res_id    (res_id),
    .res_last  (res_last)
  );

  always #5 clk = ~clk;

  function automatic int model_grant();
    if (m_rv && !res_ready) return -1;
    if (m_locked) return req_valid[m_owner] ? m_owner : -1;
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = (m_ptr + k) % NREQ;
      if (req_valid[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] model_ready();
    logic [NREQ-1:0] r;
    int g;
    r = '0;
    g = model_grant();
    if (g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  task automatic model_edge();
    int g;
    if (rst) begin
      m_ptr = 0; m_owner = 0; m_locked = 0; m_rv = 0; m_sum = '0; m_id = 0; m_last = 0;
    end else begin
      g = model_grant();
      if (g >= 0) begin
        m_sum    = 9'(req_a[8*g +: 8]) + 9'(req_b[8*g +: 8]);
        m_id     = g;
        m_last   = !req_lock[g];
        m_rv     = 1;
        m_ptr    = (g + 1) % NREQ;
        m_locked = req_lock[g];
        m_owner  = g;
      end else if (m_rv && res_ready) begin
        m_rv = 0;
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
    req_a[8*i +: 8] = a;
    req_b[8*i +: 8] = b;
  endtask

  task automatic test_reset();
    req_valid = '0;
    do_reset();
    #1;
    checks++;
    if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", res_valid); end
    checks++;
    if (res_sum !== 9'h000) begin errors++; $display("FAIL reset_sum got %h want 000", res_sum); end
    checks++;
    if (res_id !== 2'd0) begin errors++; $display("FAIL reset_id got %0d want 0", res_id); end
    checks++;
    if (res_last !== 1'b0) begin errors++; $display("FAIL reset_last got %b want 0", res_last); end
    checks++;
    if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got %b want 0000", req_ready); end
  endtask

  task automatic test_single();
    do_reset();
    res_ready = 1'b1;
    req_valid = 4'b0100;
    set_op(2, 8'hC8, 8'h64);
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready got %b want 0100", req_ready); end
    tick();
    req_valid = '0;
    checks++;
    if (res_valid !== 1'b1 || res_sum !== 9'h12C || res_id !== 2'd2 || res_last !== 1'b1) begin
      errors++;
      $display("FAIL single_result got v=%b s=%h id=%0d l=%b want v=1 s=12c id=2 l=1",
               res_valid, res_sum, res_id, res_last);
    end
    tick();
    checks++;
    if (res_valid !== 1'b0) begin errors++; $display("FAIL single_drain got %b want 0", res_valid); end
  endtask

  task automatic test_round_robin();
    int exp_id[5] = '{0, 1, 2, 3, 0};
    do_reset();
    res_ready = 1'b1;
    req_valid = 4'b1111;
    req_lock  = '0;
    for (int j = 0; j < 5; j++) begin
      req_a = {$urandom, $urandom} >> 0;
      req_b = $urandom;
      tick();
      checks++;
      if (res_valid !== 1'b1 || res_id !== IDW'(exp_id[j]) || res_sum !== m_sum) begin
        errors++;
        $display("FAIL rr_beat%0d got v=%b id=%0d s=%h want v=1 id=%0d s=%h",
                 j, res_valid, res_id, res_sum, exp_id[j], m_sum);
      end
    end
    req_valid = '0;
  endtask

  task automatic test_backpressure();
    do_reset();
    res_ready = 1'b1;
    req_valid = 4'b0001;
    set_op(0, 8'hFF, 8'hFF);
    tick();
    checks++;
    if (res_valid !== 1'b1 || res_sum !== 9'h1FE) begin
      errors++; $display("FAIL bp_first got v=%b s=%h want v=1 s=1fe", res_valid, res_sum);
    end
    res_ready = 1'b0;
    req_valid = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      req_a = $urandom;
      #1;
      checks++;
      if (req_ready !== 4'b0000) begin
        errors++; $display("FAIL bp_stall%0d_ready got %b want 0000", j, req_ready);
      end
      tick();
      checks++;
      if (res_valid !== 1'b1 || res_sum !== 9'h1FE || res_id !== 2'd0) begin
        errors++;
        $display("FAIL bp_hold%0d got v=%b s=%h id=%0d want v=1 s=1fe id=0", j, res_valid, res_sum,
                 res_id);
      end
    end
    res_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin errors++; $display("FAIL bp_release got %b want 0010", req_ready); end
    tick();
    checks++;
    if (res_valid !== 1'b1 || res_id !== 2'd1 || res_sum !== m_sum) begin
      errors++;
      $display("FAIL bp_next got v=%b id=%0d s=%h want v=1 id=1 s=%h", res_valid, res_id, res_sum,
               m_sum);
    end
    req_valid = '0;
  endtask

  task automatic test_lock();
    int         exp_id[5]   = '{1, 1, 1, 3, 0};
    bit         exp_last[5] = '{0, 0, 1, 1, 1};
    logic [3:0] exp_rdy[5]  = '{4'b0010, 4'b0010, 4'b0010, 4'b1000, 4'b0001};
    do_reset();
    res_ready = 1'b1;
    req_valid = 4'b0001;
    tick();
    for (int j = 0; j < 5; j++) begin
      req_valid = 4'b1011;
      req_lock  = (j < 2) ? 4'b1011 : 4'b1001;
      req_a = $urandom;
      req_b = $urandom;
      #1;
      checks++;
      if (req_ready !== exp_rdy[j]) begin
        errors++; $display("FAIL lock_ready%0d got %b want %b", j, req_ready, exp_rdy[j]);
      end
      req_lock = (j < 2) ? 4'b0010 : 4'b0000;
      tick();
      checks++;
      if (res_id !== IDW'(exp_id[j]) || res_last !== exp_last[j] || res_sum !== m_sum) begin
        errors++;
        $display("FAIL lock_beat%0d got id=%0d l=%b s=%h want id=%0d l=%b s=%h", j, res_id,
                 res_last, res_sum, exp_id[j], exp_last[j], m_sum);
      end
    end
    req_valid = '0;
    req_lock  = '0;
  endtask

  task automatic test_lock_gap();
    do_reset();
    res_ready = 1'b1;
    req_valid = 4'b0001;
    tick();
    req_valid = 4'b1011;
    req_lock  = 4'b0010;
    tick();
    checks++;
    if (res_id !== 2'd1 || res_last !== 1'b0) begin
      errors++; $display("FAIL gap_start got id=%0d l=%b want id=1 l=0", res_id, res_last);
    end
    req_valid = 4'b1001;
    req_lock  = 4'b0000;
    for (int j = 0; j < 3; j++) begin
      #1;
      checks++;
      if (req_ready !== 4'b0000) begin
        errors++; $display("FAIL gap_ready%0d got %b want 0000", j, req_ready);
      end
      tick();
      checks++;
      if (res_valid !== 1'b0) begin
        errors++; $display("FAIL gap_valid%0d got %b want 0", j, res_valid);
      end
    end
    req_valid = 4'b1011;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin errors++; $display("FAIL gap_resume got %b want 0010", req_ready); end
    tick();
    checks++;
    if (res_valid !== 1'b1 || res_id !== 2'd1 || res_last !== 1'b1) begin
      errors++;
      $display("FAIL gap_end got v=%b id=%0d l=%b want v=1 id=1 l=1", res_valid, res_id, res_last);
    end
    #1;
    checks++;
    if (req_ready !== 4'b1000) begin errors++; $display("FAIL gap_after got %b want 1000", req_ready); end
    req_valid = '0;
  endtask

  task automatic test_reset_mid_lock();
    do_reset();
    res_ready = 1'b0;
    req_valid = 4'b0100;
    req_lock  = 4'b0100;
    tick();
    checks++;
    if (res_valid !== 1'b1 || res_id !== 2'd2) begin
      errors++; $display("FAIL rml_pre got v=%b id=%0d want v=1 id=2", res_valid, res_id);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req_lock  = '0;
    req_valid = 4'b1111;
    res_ready = 1'b1;
    #1;
    checks++;
    if (res_valid !== 1'b0) begin errors++; $display("FAIL rml_valid got %b want 0", res_valid); end
    checks++;
    if (req_ready !== 4'b0001) begin errors++; $display("FAIL rml_ready got %b want 0001", req_ready); end
    tick();
    checks++;
    if (res_id !== 2'd0 || res_valid !== 1'b1) begin
      errors++; $display("FAIL rml_first got v=%b id=%0d want v=1 id=0", res_valid, res_id);
    end
    req_valid = '0;
  endtask

  task automatic test_random();
    do_reset();
    for (int j = 0; j < 400; j++) begin
      req_valid = NREQ'($urandom);
      req_lock  = NREQ'($urandom & $urandom);
      req_a     = $urandom;
      req_b     = $urandom;
      res_ready = ($urandom_range(0, 3) != 0);
      #1;
      checks++;
      if (req_ready !== model_ready()) begin
        errors++; $display("FAIL rand_ready%0d got %b want %b", j, req_ready, model_ready());
      end
      tick();
      checks++;
      if (res_valid !== m_rv || res_sum !== m_sum || res_id !== IDW'(m_id) || res_last !== m_last)
      begin
        errors++;
        $display("FAIL rand_out%0d got v=%b s=%h id=%0d l=%b want v=%b s=%h id=%0d l=%b", j,
                 res_valid, res_sum, res_id, res_last, m_rv, m_sum, m_id, m_last);
      end
    end
    req_valid = '0;
    req_lock  = '0;
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_lock();
    test_lock_gap();
    test_reset_mid_lock();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
